rs485_byte_tx: RTL

//  Serialises single bytes onto the RS485 half-duplex bus as 8N1 UART frames and drives the transceiver

---
 rtl/rs485_byte_tx_pkg.sv | 33 +++
 rtl/rs485_byte_tx_baud_tick_counter.sv | 44 ++++
 rtl/rs485_byte_tx.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/rs485_byte_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rs485_byte_tx_pkg
// Description : UART 8N1 frame constants, the default bit period for a
//               50 MHz clock at 115200 baud, and the line-state encoding
//               shared by the RS485 transmitter and receiver debug taps.
// Revision    : 1.0 - initial release
// ============================================================================
package rs485_byte_tx_pkg;

    localparam int   DATA_BITS            = 8;
    localparam int   STOP_BITS            = 1;
    localparam logic IDLE_LEVEL           = 1'b1;
    localparam int   DEFAULT_CLKS_PER_BIT = 434;   // 50 MHz / 115200

    // Encoding is fixed so that debug taps on the TX and RX sides decode
    // identically.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4,
        ST_TAIL  = 3'd5
    } uart_state_t;

    // Shift one bit out of the LSB end, filling the top with zero.
    function automatic logic [DATA_BITS-1:0] shift_lsb_out(input logic [DATA_BITS-1:0] v);
        return {1'b0, v[DATA_BITS-1:1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/rs485_byte_tx_baud_tick_counter.sv
`default_nettype none
// ============================================================================
// Module      : rs485_byte_tx_baud_tick_counter
// Description : Bit-period divider. Counts 0..CLKS_PER_BIT-1 and wraps.
//               i_clear holds the count at zero so a new bit period starts
//               cleanly on the first cycle after i_clear drops.
// Ports       : CLK         - system clock
//               reset       - asynchronous, active-high reset
//               i_clear     - hold count at zero
//               o_tick      - last cycle of the current bit period
//               o_tick_next - second-to-last cycle of the bit period
// Revision    : 1.0 - initial release
// ============================================================================
module rs485_byte_tx_baud_tick_counter #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic CLK,
    input  logic reset,
    input  logic i_clear,
    output logic o_tick,
    output logic o_tick_next
);

    localparam int            c_W         = $clog2(CLKS_PER_BIT);
    localparam logic [c_W-1:0] c_LAST      = c_W'(CLKS_PER_BIT - 1);
    localparam logic [c_W-1:0] c_NEXT_LAST = c_W'(CLKS_PER_BIT - 2);

    logic [c_W-1:0] r_count;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear || (r_count == c_LAST)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_W'(1);
        end
    end

    assign o_tick      = (r_count == c_LAST)      && !i_clear;
    assign o_tick_next = (r_count == c_NEXT_LAST) && !i_clear;

endmodule
`default_nettype wire

// File: rtl/rs485_byte_tx.sv
`default_nettype none
// ============================================================================
// Module      : rs485_byte_tx
// Description : RS485 half-duplex byte transmitter. Sends each accepted byte
//               as an 8N1 UART frame and drives the transceiver DE. DE is
//               raised DE_LEAD_CLKS before the first start bit and held for
//               DE_TAIL_CLKS after the stop bit so back-to-back bytes keep
//               the bus without a lead phase.
// Ports       : CLK         - system clock
//               reset       - asynchronous, active-high reset
//               tx_transmit - one-cycle send request
//               tx_data     - byte to send, sampled on acceptance
//               tx_active   - acceptance through end of stop bit
//               tx_o        - serial line to transceiver DI, idle high
//               tx_enable   - transceiver DE (/RE)
//               tx_done     - pulse in last cycle of the stop bit
// Revision    : 1.0 - initial release
// ============================================================================
module rs485_byte_tx
    import rs485_byte_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DE_LEAD_CLKS = 4,
    parameter int DE_TAIL_CLKS = 868
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       tx_transmit,
    input  logic [7:0] tx_data,
    output logic       tx_active,
    output logic       tx_o,
    output logic       tx_enable,
    output logic       tx_done
);

    localparam int c_LEAD_W = $clog2(DE_LEAD_CLKS + 1);
    localparam int c_TAIL_W = $clog2(DE_TAIL_CLKS + 1);
    localparam int c_IDX_W  = $clog2(DATA_BITS);

    localparam logic [c_LEAD_W-1:0] c_LEAD_LAST = c_LEAD_W'(DE_LEAD_CLKS - 1);
    localparam logic [c_TAIL_W-1:0] c_TAIL_LAST = c_TAIL_W'(DE_TAIL_CLKS - 1);
    localparam logic [c_IDX_W-1:0]  c_DATA_LAST = c_IDX_W'(DATA_BITS - 1);
    localparam logic [c_IDX_W-1:0]  c_STOP_LAST = c_IDX_W'(STOP_BITS - 1);

    uart_state_t            r_state;
    logic [DATA_BITS-1:0]   r_shift;
    logic [c_IDX_W-1:0]     r_bit_idx;
    logic [c_LEAD_W-1:0]    r_lead_cnt;
    logic [c_TAIL_W-1:0]    r_tail_cnt;

    logic w_baud_clr;
    logic w_tick;
    logic w_tick_next;

    // The bit divider only runs while a frame is on the wire; holding it at
    // zero elsewhere makes the start bit begin on a fresh period whether it
    // follows LEAD or TAIL.
    assign w_baud_clr = !((r_state == ST_START) || (r_state == ST_DATA) || (r_state == ST_STOP));

    rs485_byte_tx_baud_tick_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .CLK         (CLK),
        .reset       (reset),
        .i_clear     (w_baud_clr),
        .o_tick      (w_tick),
        .o_tick_next (w_tick_next)
    );

    // Outputs are updated together with the state register so that each
    // output reflects the state being entered, keeping every output a flop.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_lead_cnt <= '0;
            r_tail_cnt <= '0;
            tx_o       <= IDLE_LEVEL;
            tx_enable  <= 1'b0;
            tx_active  <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    tx_o      <= IDLE_LEVEL;
                    tx_enable <= 1'b0;
                    if (tx_transmit) begin
                        r_shift    <= tx_data;
                        r_lead_cnt <= '0;
                        tx_active  <= 1'b1;
                        tx_enable  <= 1'b1;
                        r_state    <= ST_LEAD;
                    end
                end

                ST_LEAD: begin
                    if (r_lead_cnt == c_LEAD_LAST) begin
                        r_lead_cnt <= '0;
                        tx_o       <= 1'b0;
                        r_state    <= ST_START;
                    end else begin
                        r_lead_cnt <= r_lead_cnt + c_LEAD_W'(1);
                    end
                end

                ST_START: begin
                    if (w_tick) begin
                        tx_o      <= r_shift[0];
                        r_shift   <= shift_lsb_out(r_shift);
                        r_bit_idx <= '0;
                        r_state   <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (w_tick) begin
                        if (r_bit_idx == c_DATA_LAST) begin
                            tx_o      <= IDLE_LEVEL;
                            r_bit_idx <= '0;
                            r_state   <= ST_STOP;
                        end else begin
                            tx_o      <= r_shift[0];
                            r_shift   <= shift_lsb_out(r_shift);
                            r_bit_idx <= r_bit_idx + c_IDX_W'(1);
                        end
                    end
                end

                ST_STOP: begin
                    // r_bit_idx counts stop bits here; tx_done is set one
                    // cycle early so it lands in the final stop-bit cycle.
                    if (w_tick_next && (r_bit_idx == c_STOP_LAST)) begin
                        tx_done <= 1'b1;
                    end
                    if (w_tick) begin
                        if (r_bit_idx == c_STOP_LAST) begin
                            r_bit_idx  <= '0;
                            r_tail_cnt <= '0;
                            tx_active  <= 1'b0;
                            r_state    <= ST_TAIL;
                        end else begin
                            r_bit_idx <= r_bit_idx + c_IDX_W'(1);
                        end
                    end
                end

                ST_TAIL: begin
                    // A follow-on byte wins over tail expiry, including on the
                    // last tail cycle, so DE never dips between bytes.
                    if (tx_transmit) begin
                        r_shift    <= tx_data;
                        r_tail_cnt <= '0;
                        tx_active  <= 1'b1;
                        tx_o       <= 1'b0;
                        r_state    <= ST_START;
                    end else if (r_tail_cnt == c_TAIL_LAST) begin
                        r_tail_cnt <= '0;
                        tx_enable  <= 1'b0;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_tail_cnt <= r_tail_cnt + c_TAIL_W'(1);
                    end
                end

                default: begin
                    r_state   <= ST_IDLE;
                    tx_o      <= IDLE_LEVEL;
                    tx_enable <= 1'b0;
                    tx_active <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
